chrono_lap_core: RTL and testbench
==================================

CHRONO_LAP_CORE -- requirements
Module: chrono_lap_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per count tick (100 Hz at 100 MHz).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD digits; data width W = 4*DIGITS.
REQ-003 SHALL have parameter ADDR_SIZE, default 3, lap memory address width; depth D = 2**ADDR_SIZE.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle pulse, already debounced.
REQ-008 stop  input  1  single-cycle pulse.
REQ-009 lap  input  1  single-cycle pulse; store current time.
REQ-010 clear  input  1  single-cycle pulse; zero time and laps.
REQ-011 recall  input  1  single-cycle pulse; enter or step lap recall.
REQ-012 value  output  W  BCD time shown to display, digit 0 in bits [3:0].
REQ-013 running  output  1  high in RUN.
REQ-014 recall_mode  output  1  high in RECALL.
REQ-015 lap_idx  output  ADDR_SIZE  lap index being shown in RECALL.
REQ-016 lap_count  output  ADDR_SIZE+1  number of stored laps, 0..D.
REQ-017 full  output  1  high when lap_count == D.
REQ-018 overflow  output  1  sticky, set on BCD wrap.

Function
REQ-019 SHALL implement states IDLE, RUN, STOP, RECALL.
REQ-020 Priority when pulses coincide: clear > stop > start > lap > recall; only the highest-priority applicable pulse acts.
REQ-021 IDLE: start -> RUN with prescaler = 0; other pulses have no effect.
REQ-022 RUN: stop -> STOP; clear ignored; start and recall ignored.
REQ-023 STOP: start -> RUN, prescaler kept (resume preserves the fractional tick); recall with lap_count > 0 -> RECALL, lap_idx = 0; recall with lap_count = 0 ignored; clear -> IDLE.
REQ-024 RECALL: recall -> lap_idx+1, wrapping to 0 when lap_idx+1 == lap_count; stop -> STOP; clear -> IDLE; start ignored.
REQ-025 Prescaler counts 0..TICK_DIV-1 in RUN only; tick asserted on the cycle it equals TICK_DIV-1, then it returns to 0.
REQ-026 On tick: BCD time increments by 1; each digit counts 0..9 and carries into the next digit.
REQ-027 At all-9s, tick SHALL wrap the time to 0 and set overflow; overflow is cleared only by clear or reset.
REQ-028 lap in RUN with lap_count < D: write current time (including a same-cycle tick's pre-increment value) to memory[lap_count], lap_count+1.
REQ-029 lap when full or outside RUN: ignored; memory and lap_count unchanged.
REQ-030 clear (accepted): time, prescaler, lap_count, lap_idx, overflow -> 0; memory contents need not be zeroed.
REQ-031 value is registered: it equals the time (non-RECALL) or memory[lap_idx] (RECALL) one clock after the state/time change.
REQ-032 running, recall_mode, full, lap_count registered, reflecting state after each edge with no added latency.
REQ-033 Lap memory SHALL be D x W, one write port, one read port, inferable as distributed or block RAM; read latency absorbed into REQ-031.

Reset
REQ-034 rst low SHALL asynchronously force IDLE; time, prescaler, lap_count, lap_idx, overflow, value, running, recall_mode, full all 0.
REQ-035 Reset mid-RUN or mid-RECALL SHALL abort immediately; post-reset behaviour identical to power-up.
REQ-036 Memory contents are undefined after reset and are never shown before a new lap write.

Verification (bench: TICK_DIV=4, DIGITS=2, ADDR_SIZE=2)
REQ-037 start, 40 clocks -> time 10 (value 0x10), running=1; stop, 20 clocks -> value stays 0x10.
REQ-038 start, run to 0x99, one more tick -> value 0x00, overflow=1; clear while RUN -> ignored; stop, clear -> value 0x00, overflow=0, IDLE.
REQ-039 lap at times 0x03, 0x07, 0x12, 0x20, then a fifth lap -> lap_count=4, full=1, fifth ignored; stop, recall x5 -> value 0x03, 0x07, 0x12, 0x20, 0x03.
REQ-040 stop at prescaler 2, start again -> next tick after 2 clocks, not 4.
REQ-041 start and stop in the same cycle from STOP -> stays STOP; clear and lap in the same cycle in RUN -> lap stored (clear ignored).
REQ-042 rst low asynchronously mid-RECALL -> all outputs 0 before the next clk edge; recall after reset with no laps -> ignored.

Source files
------------

// File: rtl/chrono_lap_core.sv
// Stopwatch core: BCD time counter with a prescaled tick, a small lap
// memory, lap recall, and a registered display value.
module chrono_lap_core #(
    parameter int TICK_DIV  = 1000000,
    parameter int DIGITS    = 4,
    parameter int ADDR_SIZE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   lap,
    input  logic                   clear,
    input  logic                   recall,
    output logic [4*DIGITS-1:0]    value,
    output logic                   running,
    output logic                   recall_mode,
    output logic [ADDR_SIZE-1:0]   lap_idx,
    output logic [ADDR_SIZE:0]     lap_count,
    output logic                   full,
    output logic                   overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int D  = 2 ** ADDR_SIZE;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]        PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]        PRESC_ONE = PW'(1);
    localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(D);
    localparam logic [ADDR_SIZE:0]   CNT_ONE   = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] IDX_ONE   = ADDR_SIZE'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        RECALL
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    time_q, time_d;
    logic [ADDR_SIZE:0]   count_d;
    logic [ADDR_SIZE-1:0] idx_d;
    logic            ovf_d;
    logic            tick;
    logic            lap_we;

    logic [W-1:0]    mem [D];

    // Increment a BCD word by one, rippling the carry digit by digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] t);
        logic [W-1:0] r;
        logic         carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (t[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    // Next-state logic: pulse arbitration per state, prescaler and time update.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        count_d = lap_count;
        idx_d   = lap_idx;
        ovf_d   = overflow;
        lap_we  = 1'b0;

        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PRESC_ONE;
            if (tick) begin
                time_d = bcd_inc(time_q);
                // A valid BCD word only increments to zero from all nines.
                if (time_d == '0) begin
                    ovf_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                // clear, start and recall are not accepted while running.
                if (stop) begin
                    state_d = STOP;
                end else if (lap && (lap_count != DEPTH)) begin
                    lap_we  = 1'b1;
                    count_d = lap_count + CNT_ONE;
                end
            end
            STOP: begin
                if (clear) begin
                    state_d = IDLE;
                    presc_d = '0;
                    time_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end else if (stop) begin
                    // A coincident stop outranks start and holds STOP.
                    state_d = STOP;
                end else if (start) begin
                    state_d = RUN;
                end else if (recall && (lap_count != '0)) begin
                    state_d = RECALL;
                    idx_d   = '0;
                end
            end
            RECALL: begin
                if (clear) begin
                    state_d = IDLE;
                    presc_d = '0;
                    time_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end else if (stop) begin
                    state_d = STOP;
                end else if (recall) begin
                    if (({1'b0, lap_idx} + CNT_ONE) == lap_count) begin
                        idx_d = '0;
                    end else begin
                        idx_d = lap_idx + IDX_ONE;
                    end
                end
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            time_q      <= '0;
            lap_count   <= '0;
            lap_idx     <= '0;
            overflow    <= 1'b0;
            value       <= '0;
            running     <= 1'b0;
            recall_mode <= 1'b0;
            full        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_count   <= count_d;
            lap_idx     <= idx_d;
            overflow    <= ovf_d;
            value       <= (state_q == RECALL) ? mem[lap_idx] : time_q;
            running     <= (state_d == RUN);
            recall_mode <= (state_d == RECALL);
            full        <= (count_d == DEPTH);
        end
    end

    // Lap memory write port; captures the pre-increment time on a tick cycle.
    always_ff @(posedge clk) begin
        // NOTE: the lap memory has no reset; entries are only read after being written, and leaving it unreset keeps it mappable to RAM.
        if (lap_we) begin
            mem[lap_count[ADDR_SIZE-1:0]] <= time_q;
        end
    end

endmodule

// File: tb/tb_chrono_lap_core.sv
// Directed bench for chrono_lap_core with TICK_DIV=4, DIGITS=2, ADDR_SIZE=2.
module tb_chrono_lap_core;

    localparam int TICK_DIV  = 4;
    localparam int DIGITS    = 2;
    localparam int ADDR_SIZE = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start, stop, lap, clear, recall;
    logic [4*DIGITS-1:0]  value;
    logic                 running, recall_mode, full, overflow;
    logic [ADDR_SIZE-1:0] lap_idx;
    logic [ADDR_SIZE:0]   lap_count;

    int n_vec = 0;
    int n_bad = 0;

    // Pulse masks: {clear, recall, lap, stop, start}
    localparam logic [4:0] P_START  = 5'b00001;
    localparam logic [4:0] P_STOP   = 5'b00010;
    localparam logic [4:0] P_LAP    = 5'b00100;
    localparam logic [4:0] P_RECALL = 5'b01000;
    localparam logic [4:0] P_CLEAR  = 5'b10000;

    chrono_lap_core #(
        .TICK_DIV (TICK_DIV),
        .DIGITS   (DIGITS),
        .ADDR_SIZE(ADDR_SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .lap        (lap),
        .clear      (clear),
        .recall     (recall),
        .value      (value),
        .running    (running),
        .recall_mode(recall_mode),
        .lap_idx    (lap_idx),
        .lap_count  (lap_count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, returning at a falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the selected pulses across exactly one rising edge.
    task automatic pulse(input logic [4:0] m);
        {clear, recall, lap, stop, start} = m;
        @(negedge clk);
        {clear, recall, lap, stop, start} = 5'b0;
    endtask

    logic [7:0] recall_exp [5];

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        recall_exp[0] = 8'h03;
        recall_exp[1] = 8'h07;
        recall_exp[2] = 8'h12;
        recall_exp[3] = 8'h20;
        recall_exp[4] = 8'h03;

        rst = 1'b0;
        {clear, recall, lap, stop, start} = 5'b0;
        cycles(2);
        check("reset_value", value, 0);
        check("reset_running", running, 0);
        check("reset_lap_count", lap_count, 0);
        check("reset_overflow", overflow, 0);
        rst = 1'b1;
        cycles(1);

        // Count ten ticks, then stop and hold.
        pulse(P_START);
        check("run_running", running, 1);
        cycles(40);
        pulse(P_STOP);
        check("run40_value", value, 8'h10);
        check("stop_running", running, 0);
        cycles(20);
        check("stop_hold_value", value, 8'h10);

        // Wrap from 99 to 00 with overflow; clear ignored in RUN.
        pulse(P_CLEAR);
        cycles(1);
        check("clear_value", value, 0);
        pulse(P_START);
        cycles(397);
        check("at_99_value", value, 8'h99);
        check("at_99_overflow", overflow, 0);
        cycles(4);
        check("wrap_value", value, 8'h00);
        check("wrap_overflow", overflow, 1);
        pulse(P_CLEAR);
        check("clear_in_run_running", running, 1);
        check("clear_in_run_overflow", overflow, 1);
        pulse(P_STOP);
        pulse(P_CLEAR);
        check("clear_stop_value", value, 0);
        check("clear_stop_overflow", overflow, 0);
        check("clear_stop_running", running, 0);

        // Four laps fill the memory; fifth ignored; recall cycles through.
        pulse(P_START);
        cycles(12);
        pulse(P_LAP);
        cycles(15);
        pulse(P_LAP);
        cycles(19);
        pulse(P_LAP);
        cycles(31);
        pulse(P_LAP);
        check("four_laps_count", lap_count, 4);
        check("four_laps_full", full, 1);
        cycles(3);
        pulse(P_LAP);
        check("fifth_lap_count", lap_count, 4);
        pulse(P_STOP);
        for (int i = 0; i < 5; i++) begin
            pulse(P_RECALL);
            cycles(1);
            check($sformatf("recall%0d_value", i), value, recall_exp[i]);
            check($sformatf("recall%0d_idx", i), lap_idx, i % 4);
        end
        check("recall_mode", recall_mode, 1);
        pulse(P_STOP);
        check("recall_stop_mode", recall_mode, 0);

        // Coincident start+stop from STOP holds STOP.
        pulse(P_START | P_STOP);
        check("start_stop_running", running, 0);

        // Coincident clear+lap in RUN stores the lap.
        pulse(P_CLEAR);
        check("clear_laps_count", lap_count, 0);
        pulse(P_START);
        cycles(5);
        pulse(P_CLEAR | P_LAP);
        check("clear_lap_count", lap_count, 1);
        check("clear_lap_running", running, 1);
        pulse(P_STOP);
        pulse(P_RECALL);
        cycles(1);
        check("clear_lap_stored", value, 8'h01);

        // Resume keeps the fractional tick.
        pulse(P_CLEAR);
        pulse(P_START);
        cycles(1);
        pulse(P_STOP);
        pulse(P_START);
        cycles(2);
        check("resume_before_tick", value, 8'h00);
        cycles(1);
        check("resume_tick_after_2", value, 8'h01);

        // Asynchronous reset mid-RECALL.
        pulse(P_LAP);
        pulse(P_STOP);
        pulse(P_RECALL);
        cycles(1);
        check("pre_reset_recall", recall_mode, 1);
        check("pre_reset_value", value, 8'h01);
        #2 rst = 1'b0;
        #1;
        check("async_value", value, 0);
        check("async_recall_mode", recall_mode, 0);
        check("async_lap_count", lap_count, 0);
        check("async_lap_idx", lap_idx, 0);
        check("async_running", running, 0);
        check("async_full", full, 0);
        check("async_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        cycles(1);
        pulse(P_RECALL);
        check("recall_no_laps", recall_mode, 0);
        cycles(1);
        check("recall_no_laps_value", value, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
